// File: rtl/sequence_ram_ctrl.sv
// Record/playback controller for a 64x10 single-port synchronous RAM.
// Records notes on record-button edges and loops them back at a fixed tempo.
module sequence_ram_ctrl #(
  parameter int TEMPO_DIV = 12500000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       record_mode,
  input  logic       play_mode,
  input  logic       record,
  input  logic       clear,
  input  logic [9:0] note_sequence,
  input  logic [9:0] ram_q,
  output logic [5:0] ram_address,
  output logic [9:0] ram_data,
  output logic       ram_wren,
  output logic [9:0] play_notes,
  output logic       play_step,
  output logic [6:0] length,
  output logic       full
);

  localparam int TW = (TEMPO_DIV > 1) ? $clog2(TEMPO_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TEMPO_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, REC, REC_WR, PLAY_ADDR, PLAY_DATA, PLAY_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    len_q, len_d;
  logic [5:0]    rd_q, rd_d;
  logic [9:0]    notes_q, notes_d;
  logic          step_q, step_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [9:0]    data_q, data_d;
  logic          rec_prev_q;

  logic rec_edge, is_full, play_abort;

  assign rec_edge   = record & ~rec_prev_q;
  assign is_full    = (len_q == 7'd64);
  assign play_abort = ~play_mode | record_mode;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rd_d    = rd_q;
    notes_d = notes_q;
    step_d  = 1'b0;
    tick_d  = tick_q;
    data_d  = data_q;
    if (clear) begin
      state_d = IDLE;
      len_d   = '0;
      rd_d    = '0;
      notes_d = '0;
      tick_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          notes_d = '0;
          if (record_mode) state_d = REC;
          else if (play_mode && len_q != 7'd0) begin
            state_d = PLAY_ADDR;
            rd_d    = '0;
          end
        end
        REC: begin
          notes_d = '0;
          if (!record_mode) state_d = IDLE;
          else if (rec_edge && !is_full) begin
            state_d = REC_WR;
            data_d  = note_sequence;
          end
        end
        REC_WR: begin
          len_d   = len_q + 7'd1;
          state_d = REC;
        end
        PLAY_ADDR: begin
          if (play_abort) begin
            state_d = IDLE;
            notes_d = '0;
          end else state_d = PLAY_DATA;
        end
        PLAY_DATA: begin
          if (play_abort) begin
            state_d = IDLE;
            notes_d = '0;
          end else begin
            notes_d = ram_q;
            step_d  = 1'b1;
            tick_d  = '0;
            state_d = PLAY_HOLD;
          end
        end
        PLAY_HOLD: begin
          if (play_abort) begin
            state_d = IDLE;
            notes_d = '0;
          end else if (tick_q == TICK_MAX) begin
            // wrap on the stored length, not the RAM depth
            rd_d    = (({1'b0, rd_q} + 7'd1) == len_q) ? 6'd0 : rd_q + 6'd1;
            state_d = PLAY_ADDR;
          end else tick_d = tick_q + TW'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      len_q      <= '0;
      rd_q       <= '0;
      notes_q    <= '0;
      step_q     <= 1'b0;
      tick_q     <= '0;
      data_q     <= '0;
      rec_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rd_q       <= rd_d;
      notes_q    <= notes_d;
      step_q     <= step_d;
      tick_q     <= tick_d;
      data_q     <= data_d;
      rec_prev_q <= record;
    end
  end

  // write pointer is the low bits of length; full blocks any wrap
  assign ram_address = (state_q == REC || state_q == REC_WR) ? len_q[5:0] : rd_q;
  assign ram_wren    = (state_q == REC_WR) && !clear;
  assign ram_data    = data_q;
  assign play_notes  = notes_q;
  assign play_step   = step_q;
  assign length      = len_q;
  assign full        = is_full;

endmodule

// File: tb/tb_sequence_ram_ctrl.sv
// Directed bench for sequence_ram_ctrl with a behavioural 64x10 synchronous RAM.
module tb_sequence_ram_ctrl;

  logic       clock = 1'b0;
  logic       resetn;
  logic       record_mode, play_mode, record, clear;
  logic [9:0] note_sequence;
  logic [9:0] ram_q;
  logic [5:0] ram_address;
  logic [9:0] ram_data;
  logic       ram_wren;
  logic [9:0] play_notes;
  logic       play_step;
  logic [6:0] length;
  logic       full;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] mem [64];

  sequence_ram_ctrl #(.TEMPO_DIV(4)) dut (
    .clock(clock), .resetn(resetn), .record_mode(record_mode), .play_mode(play_mode),
    .record(record), .clear(clear), .note_sequence(note_sequence), .ram_q(ram_q),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .play_notes(play_notes), .play_step(play_step), .length(length), .full(full)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // one record press held for two cycles: exactly one write expected
  task automatic rec_pulse(input logic [9:0] note, input int idx);
    note_sequence = note;
    record = 1'b1;
    tick();
    chk("wren_on", 32'(ram_wren), 32'd1);
    chk("wr_addr", 32'(ram_address), 32'(idx));
    chk("wr_data", 32'(ram_data), 32'(note));
    tick();
    chk("hold_no_wr", 32'(ram_wren), 32'd0);
    record = 1'b0;
    tick();
    chk("len_inc", 32'(length), 32'(idx + 1));
    chk("full_flag", 32'(full), 32'((idx + 1) == 64));
  endtask

  initial begin
    logic [9:0] seq3 [3];
    seq3[0] = 10'h001; seq3[1] = 10'h002; seq3[2] = 10'h004;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    resetn = 1'b0; record_mode = 0; play_mode = 0; record = 0; clear = 0;
    note_sequence = '0;
    #3;
    chk("rst_wren", 32'(ram_wren), 32'd0);
    chk("rst_len", 32'(length), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_notes", 32'(play_notes), 32'd0);
    chk("rst_step", 32'(play_step), 32'd0);
    tick(); tick();
    resetn = 1'b1;
    tick();

    // playback with nothing stored stays idle
    play_mode = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("empty_notes", 32'(play_notes), 32'd0);
      chk("empty_step", 32'(play_step), 32'd0);
    end
    play_mode = 1'b0;

    record_mode = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) rec_pulse(seq3[i], i);

    record_mode = 1'b0;
    tick();
    play_mode = 1'b1;
    tick();
    chk("pa_notes", 32'(play_notes), 32'd0);
    tick();
    chk("pd_notes", 32'(play_notes), 32'd0);
    chk("pd_step", 32'(play_step), 32'd0);
    tick();
    chk("play0_notes", 32'(play_notes), 32'h001);
    chk("play0_step", 32'(play_step), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      for (int c = 0; c < 5; c++) begin
        tick();
        chk("hold_notes", 32'(play_notes), 32'(seq3[(k - 1) % 3]));
        chk("hold_step", 32'(play_step), 32'd0);
        chk("play_nowr", 32'(ram_wren), 32'd0);
      end
      tick();
      chk("step_notes", 32'(play_notes), 32'(seq3[k % 3]));
      chk("step_pulse", 32'(play_step), 32'd1);
    end

    // record_mode preempts playback
    record_mode = 1'b1;
    tick();
    chk("abort_notes", 32'(play_notes), 32'd0);
    chk("abort_wren", 32'(ram_wren), 32'd0);
    tick();
    chk("rec_addr", 32'(ram_address), 32'd3);
    chk("rec_notes", 32'(play_notes), 32'd0);

    // clear beats a simultaneous record edge
    note_sequence = 10'h3FF;
    record = 1'b1;
    clear = 1'b1;
    tick();
    chk("clr_wren", 32'(ram_wren), 32'd0);
    chk("clr_len", 32'(length), 32'd0);
    clear = 1'b0;
    record = 1'b0;
    tick();
    chk("clr_wren2", 32'(ram_wren), 32'd0);
    chk("clr_len2", 32'(length), 32'd0);

    tick();
    for (int i = 0; i < 64; i++) rec_pulse(10'(i * 7 + 1), i);
    record = 1'b1;
    note_sequence = 10'h155;
    tick();
    chk("full_nowr", 32'(ram_wren), 32'd0);
    tick();
    chk("full_nowr2", 32'(ram_wren), 32'd0);
    record = 1'b0;
    tick();
    chk("full_len", 32'(length), 32'd64);
    chk("full_set", 32'(full), 32'd1);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_full", 32'(full), 32'd0);
    tick();
    note_sequence = 10'h2AA;
    record = 1'b1;
    tick();
    chk("prerst_wren", 32'(ram_wren), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_wren", 32'(ram_wren), 32'd0);
    chk("arst_len", 32'(length), 32'd0);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_notes", 32'(play_notes), 32'd0);
    chk("arst_step", 32'(play_step), 32'd0);
    chk("arst_addr", 32'(ram_address), 32'd0);
    record = 1'b0;
    record_mode = 1'b0;
    play_mode = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    chk("post_len", 32'(length), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sequence_ram_ctrl.md
SEQUENCE_RAM_CTRL -- requirements
Module: sequence_ram_ctrl

Interface
REQ-001 SHALL have parameter TEMPO_DIV, default 12500000, clock cycles each played entry is held in PLAY_HOLD (at least 1).
REQ-002 SHALL have ports:
- clock  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- record_mode  in  1  level, selects record operation
- play_mode  in  1  level, selects playback operation
- record  in  1  level, save button, already synchronized
- clear  in  1  level, erase stored sequence
- note_sequence  in  10  note bits to store
- ram_q  in  10  RAM read data
- ram_address  out  6  RAM address
- ram_data  out  10  RAM write data
- ram_wren  out  1  RAM write enable
- play_notes  out  10  currently sounding notes
- play_step  out  1  one-cycle pulse when play_notes updates
- length  out  7  stored entry count, 0..64
- full  out  1  length==64

Function
REQ-003 SHALL drive a 64x10 single-port RAM that registers address/data/wren on the rising edge; ram_q is valid the cycle after the address is sampled.
REQ-004 SHALL implement states IDLE, REC, REC_WR, PLAY_ADDR, PLAY_DATA, PLAY_HOLD.
REQ-005 IDLE: record_mode=1 -> REC; else play_mode=1 and length!=0 -> PLAY_ADDR with rd_ptr=0; else stay.
REQ-006 record_mode SHALL take priority over play_mode when both are 1.
REQ-007 Record edge: record=1 while the previous-cycle record was 0.
REQ-008 REC: record_mode=0 -> IDLE; record edge with full=0 -> REC_WR, note_sequence captured into ram_data on that edge; record edge with full=1 -> ignored, no write.
REQ-009 REC_WR: exactly one cycle; ram_wren=1, ram_address=wr_ptr; then wr_ptr+1, length+1, -> REC.
REQ-010 ram_wren SHALL be 1 only in REC_WR.
REQ-011 wr_ptr SHALL equal length[5:0]; after the 64th write full=1, and wr_ptr never wraps over stored data.
REQ-012 Holding record high SHALL write one entry only; a new edge is required for each entry.
REQ-013 PLAY_ADDR: ram_address=rd_ptr for one cycle -> PLAY_DATA.
REQ-014 PLAY_DATA: one cycle; at its end ram_q latched into play_notes, play_step=1 next cycle, tick counter cleared -> PLAY_HOLD.
REQ-015 PLAY_HOLD: TEMPO_DIV cycles; then rd_ptr = (rd_ptr+1==length) ? 0 : rd_ptr+1, -> PLAY_ADDR. The step period SHALL be TEMPO_DIV+2 cycles.
REQ-016 Playback SHALL loop entries 0..length-1 indefinitely; length==1 repeats entry 0.
REQ-017 play_notes SHALL hold its previous value during PLAY_ADDR/PLAY_DATA (no gap between steps).
REQ-018 In any PLAY_* state, play_mode=0 or record_mode=1 -> IDLE next cycle; the pending read is discarded; play_notes=0.
REQ-019 ram_address SHALL be wr_ptr in REC/REC_WR, rd_ptr otherwise.
REQ-020 clear=1 in any state -> IDLE; length=0, wr_ptr=0, rd_ptr=0, play_notes=0, no write that cycle.
REQ-021 clear SHALL override a simultaneous record edge; RAM contents need not be erased.
REQ-022 play_notes SHALL be 0 in IDLE, REC and REC_WR.

Reset
REQ-023 resetn=0 SHALL immediately force IDLE, wr_ptr=0, rd_ptr=0, length=0, full=0, ram_wren=0, play_notes=0, play_step=0, tick=0, previous record=0.
REQ-024 A reset during REC_WR SHALL drop ram_wren asynchronously; length is unchanged by the aborted write.

Verification (TEMPO_DIV=4)
REQ-025 record_mode=1, three record pulses with note_sequence 0x001, 0x002, 0x004 -> three single-cycle ram_wren at addresses 0, 1, 2; length=3.
REQ-026 After REQ-025, play_mode=1 -> play_notes sequence 0x001, 0x002, 0x004, 0x001..., play_step every 6 cycles.
REQ-027 64 record pulses then a 65th -> full=1 after the 64th; the 65th gives no ram_wren; length=64.
REQ-028 play_mode=1 with length=0 -> stays IDLE, play_notes=0, no play_step.
REQ-029 Mid-playback record_mode=1 -> IDLE then REC next cycles, play_notes=0; clear plus simultaneous record edge -> no write, length=0.
REQ-030 resetn low during REC_WR -> ram_wren falls without a clock, all outputs at reset values.
